// File: rtl/disp_share_arb.sv
// Round-robin owner arbiter for the shared 8-digit seven-segment display.
// Grants one requester at a time with a minimum dwell and registers its value into disp_num.
module disp_share_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [31:0] IDLE_VALUE  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]      gnt,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic [31:0]           disp_num
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_HOLD  = 1'b1;
    localparam logic [3:0]  NQ      = 4'(N_REQ);
    localparam logic [15:0] CNT_MAX = 16'(HOLD_CYCLES - 1);
    localparam logic [2:0]  PTR_RST = 3'(N_REQ - 1);

    logic [0:0]         r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [2:0]         r_owner;
    logic [2:0]         r_ptr;
    logic [15:0]        r_cnt;
    logic [31:0]        r_disp;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    logic [3:0]         w_off;
    logic [3:0]         w_sum;
    logic [2:0]         w_sel;
    logic [31:0]        w_odata;
    logic               w_own_req;
    logic               w_others;
    logic               w_release;
    logic               w_preempt;

    // Rotate req so bit 0 is index ptr+1; the lowest set bit is then the winner's offset.
    always_comb begin
        w_dbl   = {req, req} >> ({1'b0, r_ptr} + 4'd1);
        w_rot   = w_dbl[N_REQ-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 4'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + 4'd1 + w_off;
        w_sel = (w_sum >= NQ) ? 3'(w_sum - NQ) : w_sum[2:0];
    end

    always_comb begin
        w_odata = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) begin
                w_odata = data_in[32*k +: 32];
            end
        end
    end

    assign w_own_req = |(req & r_gnt);
    assign w_others  = |(req & ~r_gnt);
    assign w_release = !w_own_req;
    assign w_preempt = w_own_req && (r_cnt == CNT_MAX) && w_others;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
            r_disp  <= IDLE_VALUE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_HOLD;
                        r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
                        r_owner <= w_sel;
                        r_ptr   <= w_sel;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_disp <= w_odata;
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    // Release and preempt share the same outcome, so no priority is needed.
                    if (w_release || w_preempt) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign owner    = r_owner;
    assign busy     = |r_gnt;
    assign disp_num = r_disp;

endmodule
